// File: rtl/pkt_axis_pkg.sv
// Shared types and constants for the packet egress stage.
// Beat layout in the data FIFO: {last, keep, data}.
package pkt_axis_pkg;

    localparam logic [1:0] TUSER_TAIL = 2'b10;
    localparam int DATA_W = 256;
    localparam int KEEP_W = 32;
    localparam int BEAT_W = DATA_W + KEEP_W + 1;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/sdp_ram_288.sv
// Simple dual-port RAM, one write port, one read port.
// Read data is registered: valid the cycle after re.
module sdp_ram_288 #(
    parameter int AW = 9,
    parameter int W  = 289
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pkt_axis_tx.sv
// Store-and-forward egress FIFO from the data cache to a 256b AXIS master.
// Packets become visible to the read side only once committed at their tail.
module pkt_axis_tx
    import pkt_axis_pkg::*;
#(
    parameter int DEPTH_LOG2    = 9,
    parameter int MAX_PKT_BEATS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_data_wr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_tkeep,
    input  logic [1:0]        in_tuser,
    input  logic              in_valid_wr,
    input  logic              in_valid,
    output logic              out_alf,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       pkt_in_cnt,
    output logic [31:0]       pkt_out_cnt,
    output logic [31:0]       pkt_drop_cnt
);

    // Pointers carry one extra MSB so full and empty never alias.
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] FULL_LVL = PW'((1 << DEPTH_LOG2) - 1);
    localparam logic [PW-1:0] ALF_LVL  = PW'(MAX_PKT_BEATS);

    // wr_ptr: next write slot, including uncommitted beats.
    // commit_ptr: end of the last committed packet.
    // raddr: next RAM slot to fetch into the skid buffer.
    // rd_ptr: slots released to the sink (handshaken beats).
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] raddr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] used;

    logic          drop_q;
    logic          is_tail;
    logic          full;
    logic          drop_now;
    logic          ram_we;
    logic          verdict_bad;
    logic          commit;
    logic          rollback;
    beat_t         wbeat;

    logic [PW-1:0] pkt_cnt;
    logic [PW-1:0] pkt_cnt_d;
    rd_state_t     state;
    rd_state_t     state_d;

    logic              rd_en;
    logic              rd_vld_q;
    logic              rd_allow;
    logic [BEAT_W-1:0] ram_rdata;
    beat_t             ram_beat;

    beat_t       skid0;
    beat_t       skid1;
    logic [1:0]  skid_cnt;
    logic [2:0]  occ_after;
    logic        pop;
    logic        tlast_hs;
    logic        alf_q;

    // Write side: overflow, verdict and commit decode for the incoming beat.
    always_comb begin
        used        = wr_ptr - rd_ptr;
        is_tail     = (in_tuser == TUSER_TAIL);
        full        = (used == FULL_LVL);
        drop_now    = in_data_wr && (drop_q || full);
        ram_we      = in_data_wr && !drop_now;
        verdict_bad = in_valid_wr && !in_valid;
        commit      = in_data_wr && is_tail && !drop_now && !verdict_bad;
        rollback    = in_data_wr && is_tail && (drop_now || verdict_bad);
        wbeat.last  = is_tail;
        wbeat.keep  = in_tkeep;
        wbeat.data  = in_data;
    end

    // Write pointer, commit boundary and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            drop_q     <= 1'b0;
        end else begin
            if (rollback) begin
                wr_ptr <= commit_ptr;
            end else if (ram_we) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (commit) begin
                commit_ptr <= wr_ptr + ONE;
            end
            if (in_data_wr && is_tail) begin
                drop_q <= 1'b0;
            end else if (in_data_wr && full) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Ingress packet statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_in_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (commit) begin
                pkt_in_cnt <= pkt_in_cnt + 32'd1;
            end
            if (rollback) begin
                pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
            end
        end
    end

    sdp_ram_288 #(
        .AW (DEPTH_LOG2),
        .W  (BEAT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (wbeat),
        .re    (rd_en),
        .raddr (raddr[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    assign ram_beat = beat_t'(ram_rdata);

    // Read side: fetch only committed beats, and only if the skid
    // buffer can absorb the beat when it returns next cycle.
    always_comb begin
        pop       = m_axis_tvalid && m_axis_tready;
        tlast_hs  = pop && m_axis_tlast;
        occ_after = {1'b0, skid_cnt} + {2'b0, rd_vld_q} - {2'b0, pop};
        rd_allow  = (state == RD_SEND) || (pkt_cnt != '0);
        rd_en     = rd_allow && (raddr != commit_ptr) && (occ_after < 3'd2);
    end

    // Committed-but-unsent packet count, next value.
    always_comb begin
        pkt_cnt_d = pkt_cnt;
        case ({commit, tlast_hs})
            2'b10:   pkt_cnt_d = pkt_cnt + ONE;
            2'b01:   pkt_cnt_d = pkt_cnt - ONE;
            default: pkt_cnt_d = pkt_cnt;
        endcase
    end

    // Read FSM next state.
    always_comb begin
        state_d = state;
        unique case (state)
            RD_IDLE: begin
                if (pkt_cnt != '0) begin
                    state_d = RD_SEND;
                end
            end
            RD_SEND: begin
                if (tlast_hs && (pkt_cnt_d == '0)) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Read FSM, packet count and read pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RD_IDLE;
            pkt_cnt  <= '0;
            raddr    <= '0;
            rd_ptr   <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state    <= state_d;
            pkt_cnt  <= pkt_cnt_d;
            rd_vld_q <= rd_en;
            if (rd_en) begin
                raddr <= raddr + ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    // Two-entry skid buffer; skid0 is the registered AXIS head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid0    <= '0;
            skid1    <= '0;
            skid_cnt <= 2'd0;
        end else begin
            case ({rd_vld_q, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) begin
                        skid0 <= ram_beat;
                    end else begin
                        skid1 <= ram_beat;
                    end
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= ram_beat;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= ram_beat;
                    end
                end
                default: begin
                    skid_cnt <= skid_cnt;
                end
            endcase
        end
    end

    // Egress statistics and registered almost-full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_out_cnt <= '0;
            alf_q       <= 1'b0;
        end else begin
            if (tlast_hs) begin
                pkt_out_cnt <= pkt_out_cnt + 32'd1;
            end
            alf_q <= ((FULL_LVL - used) < ALF_LVL);
        end
    end

    assign out_alf       = alf_q;
    assign m_axis_tvalid = (skid_cnt != 2'd0);
    assign m_axis_tdata  = skid0.data;
    assign m_axis_tkeep  = skid0.keep;
    assign m_axis_tlast  = skid0.last;

endmodule

// File: tb/tb_pkt_axis_tx.sv
// Directed bench for pkt_axis_tx with an output scoreboard.
// Expected beats are queued by the writer for every packet that should commit.
module tb_pkt_axis_tx;
    import pkt_axis_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_data_wr;
    logic [DATA_W-1:0] in_data;
    logic [KEEP_W-1:0] in_tkeep;
    logic [1:0]        in_tuser;
    logic              in_valid_wr;
    logic              in_valid;
    logic              out_alf;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [31:0]       pkt_in_cnt;
    logic [31:0]       pkt_out_cnt;
    logic [31:0]       pkt_drop_cnt;

    pkt_axis_tx dut (
        .clk           (clk),
        .rst           (rst),
        .in_data_wr    (in_data_wr),
        .in_data       (in_data),
        .in_tkeep      (in_tkeep),
        .in_tuser      (in_tuser),
        .in_valid_wr   (in_valid_wr),
        .in_valid      (in_valid),
        .out_alf       (out_alf),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_in_cnt    (pkt_in_cnt),
        .pkt_out_cnt   (pkt_out_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk;
    int    n_pass;
    beat_t expq[$];
    int    rx_beats;
    int    bubbles;
    logic  bubble_win;
    logic  pv;
    logic  pr;
    beat_t pd;
    int    exp_in;
    int    exp_drop;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int id, input int b);
        logic [255:0] r;
        logic [31:0]  w;
        w = 32'(id) * 32'h0100_0193 + 32'(b);
        for (int k = 0; k < 8; k++) begin
            r[k*32 +: 32] = w ^ (32'(k) * 32'h1111_1111);
        end
        return r;
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
        in_data_wr  = 1'b0;
        in_valid_wr = 1'b0;
        in_valid    = 1'b0;
        in_tuser    = 2'b00;
    endtask

    task automatic send_pkt(input int id, input int len, input logic vwr,
                            input logic verdict, input logic [31:0] tkeep_tail,
                            input logic expect_out);
        beat_t e;
        for (int b = 0; b < len; b++) begin
            @(posedge clk);
            #1;
            in_data_wr  = 1'b1;
            in_data     = pat(id, b);
            in_tkeep    = (b == len - 1) ? tkeep_tail : 32'hFFFF_FFFF;
            in_tuser    = (b == len - 1) ? 2'b10 : ((b % 2 == 1) ? 2'b11 : 2'b01);
            in_valid_wr = (b == len - 1) && vwr;
            in_valid    = verdict;
            if (expect_out) begin
                e.last = (b == len - 1);
                e.keep = in_tkeep;
                e.data = in_data;
                expq.push_back(e);
            end
        end
    endtask

    task automatic wait_rx(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (rx_beats < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 256'(rx_beats), 256'(target));
    endtask

    // Output monitor: scoreboard, stall stability and bubble count.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 256'(m_axis_tvalid), 256'(1));
                chk("hold_data", m_axis_tdata, pd.data);
                chk("hold_keep_last", 256'({m_axis_tkeep, m_axis_tlast}),
                    256'({pd.keep, pd.last}));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                rx_beats++;
                if (expq.size() == 0) begin
                    chk("sb_extra_beat", 256'(1), 256'(0));
                end else begin
                    e = expq.pop_front();
                    chk("sb_data", m_axis_tdata, e.data);
                    chk("sb_keep_last", 256'({m_axis_tkeep, m_axis_tlast}),
                        256'({e.keep, e.last}));
                end
            end
            if (bubble_win && m_axis_tready && !m_axis_tvalid && expq.size() > 0) begin
                bubbles++;
            end
            pv = m_axis_tvalid;
            pr = m_axis_tready;
            pd.data = m_axis_tdata;
            pd.keep = m_axis_tkeep;
            pd.last = m_axis_tlast;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout rx=%0d", rx_beats);
        $fatal(1);
    end

    initial begin
        int   base;
        int   n;
        int   len;
        logic bad;
        logic vwr;
        logic wdone;
        n_chk = 0; n_pass = 0; rx_beats = 0; bubbles = 0;
        bubble_win = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0;
        exp_in = 0; exp_drop = 0;
        rst = 1'b1;
        in_data_wr = 1'b0; in_data = '0; in_tkeep = '0; in_tuser = 2'b00;
        in_valid_wr = 1'b0; in_valid = 1'b0; m_axis_tready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_tdata", m_axis_tdata, 256'(0));
        chk("rst_tkeep_tlast", 256'({m_axis_tkeep, m_axis_tlast}), 256'(0));
        chk("rst_alf", 256'(out_alf), 256'(0));
        chk("rst_cnts", 256'({pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt}), 256'(0));
        rst = 1'b0;

        // Single 3-beat packet, full-rate sink.
        m_axis_tready = 1'b1;
        send_pkt(1, 3, 1'b1, 1'b1, 32'h0000_FFFF, 1'b1);
        idle();
        exp_in += 1;
        wait_rx(3, 20, "t1_beats");
        repeat (2) @(posedge clk);
        #1;
        chk("t1_in_cnt", 256'(pkt_in_cnt), 256'(1));
        chk("t1_out_cnt", 256'(pkt_out_cnt), 256'(1));

        // Stray verdict, dropped 4-beat packet, good 2-beat packet.
        @(posedge clk);
        #1;
        in_valid_wr = 1'b1;
        in_valid    = 1'b0;
        idle();
        send_pkt(2, 4, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        send_pkt(3, 2, 1'b1, 1'b1, 32'h0000_000F, 1'b1);
        idle();
        exp_in += 1; exp_drop += 1;
        wait_rx(5, 30, "t2_beats");
        repeat (4) @(posedge clk);
        #1;
        chk("t2_no_extra", 256'(rx_beats), 256'(5));
        chk("t2_drop_cnt", 256'(pkt_drop_cnt), 256'(1));
        chk("t2_in_out", 256'({pkt_in_cnt, pkt_out_cnt}), 256'({32'd2, 32'd2}));
        chk("t2_usage", 256'(dut.wr_ptr - dut.rd_ptr), 256'(0));

        // Fill to 448 beats with a stalled sink, then overflow a 70-beat packet.
        m_axis_tready = 1'b0;
        for (int p = 0; p < 6; p++) begin
            send_pkt(10 + p, 64, (p % 2 == 1), 1'b1, 32'(p + 1), 1'b1);
        end
        idle();
        @(posedge clk);
        #1;
        chk("t3_alf_384", 256'(out_alf), 256'(0));
        send_pkt(16, 64, 1'b1, 1'b1, 32'h8000_0001, 1'b1);
        idle();
        exp_in += 7;
        chk("t3_alf_lag", 256'(out_alf), 256'(0));
        @(posedge clk);
        #1;
        chk("t3_alf_448", 256'(out_alf), 256'(1));
        send_pkt(17, 70, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        idle();
        exp_drop += 1;
        @(posedge clk);
        #1;
        chk("t3_ovf_drop", 256'(pkt_drop_cnt), 256'(exp_drop));
        chk("t3_ovf_in", 256'(pkt_in_cnt), 256'(exp_in));
        chk("t3_ovf_alf", 256'(out_alf), 256'(1));
        bubble_win    = 1'b1;
        m_axis_tready = 1'b1;
        wait_rx(5 + 64, 100, "t3_drain1");
        @(posedge clk);
        #1;
        chk("t3_alf_released", 256'(out_alf), 256'(0));
        wait_rx(5 + 448, 600, "t3_drain_all");
        bubble_win = 1'b0;
        chk("t3_bubbles", 256'(bubbles), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("t3_out_cnt", 256'(pkt_out_cnt), 256'(exp_in));

        // 100 back-to-back packets under a 50% random sink.
        base  = rx_beats;
        n     = 0;
        wdone = 1'b0;
        fork
            begin
                for (int p = 0; p < 100; p++) begin
                    len = int'($urandom_range(1, 6));
                    bad = (p % 9 == 4);
                    vwr = (p % 3 != 0) || bad;
                    if (out_alf) begin
                        idle();
                        for (int w = 0; w < 500 && out_alf; w++) begin
                            @(posedge clk);
                        end
                    end
                    send_pkt(100 + p, len, vwr, !bad, $urandom, !bad);
                    if (bad) begin
                        exp_drop += 1;
                    end else begin
                        exp_in += 1;
                        n += len;
                    end
                end
                idle();
                wdone = 1'b1;
            end
            begin
                while (!wdone) begin
                    @(posedge clk);
                    #1;
                    m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_rx(base + n, 2000, "t4_beats");
        repeat (3) @(posedge clk);
        #1;
        chk("t4_in_cnt", 256'(pkt_in_cnt), 256'(exp_in));
        chk("t4_out_cnt", 256'(pkt_out_cnt), 256'(exp_in));
        chk("t4_drop_cnt", 256'(pkt_drop_cnt), 256'(exp_drop));
        chk("t4_sb_empty", 256'(expq.size()), 256'(0));

        // Reset in the middle of an outgoing packet.
        base = rx_beats;
        send_pkt(300, 20, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        idle();
        wait_rx(base + 3, 20, "t5_partial");
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("t5_rst_cnts", 256'({pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt}), 256'(0));
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = rx_beats;
        send_pkt(301, 1, 1'b1, 1'b1, 32'h0000_0001, 1'b1);
        idle();
        chk("t5_lat_t1", 256'(m_axis_tvalid), 256'(0));
        @(posedge clk);
        #1;
        chk("t5_lat_t2", 256'(m_axis_tvalid), 256'(0));
        @(posedge clk);
        #1;
        chk("t5_lat_t3", 256'(m_axis_tvalid), 256'(1));
        wait_rx(base + 1, 10, "t5_beat");
        repeat (2) @(posedge clk);
        #1;
        chk("t5_cnts", 256'({pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt}),
            256'({32'd1, 32'd1, 32'd0}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
